ps2_key_capture: RTL and testbench
==================================

// Module: ps2_key_capture
// PURPOSE
//  Upstream of the enigma core. Receives PS/2 keyboard frames (scan-code set 2) and decodes letter
//  make-codes to uppercase ASCII. Emits char_input plus a one-cycle char_pressed strobe, which the
//  enigma consumes directly. All other keys, break sequences and typematic repeats are discarded.
// PARAMETERS
//  FILTER_LEN      8      ps2_clk glitch filter; level accepted after FILTER_LEN equal samples
//  TIMEOUT_CYCLES  50000  idle clk cycles mid-frame before abort (1 ms at 50 MHz)
// PORTS
//  clk          in   1  system clock; single clock domain
//  resetn       in   1  synchronous, active-low reset
//  ps2_clk      in   1  raw PS/2 clock, asynchronous
//  ps2_dat      in   1  raw PS/2 data, asynchronous
//  char_input   out  8  ASCII 0x41..0x5A of last accepted key; held between strobes
//  char_pressed out  1  one-cycle strobe; char_input is valid in that cycle
//  frame_err    out  1  one-cycle strobe on parity, start-bit, stop-bit or timeout error
// BEHAVIOUR
//  Reset (resetn=0 at posedge): char_input=8'h00, char_pressed=0, frame_err=0, both FSMs to idle,
//   held_code=0, filter and sync regs preset to 1. Reset mid-frame discards the partial frame.
//  Input: 2-FF synchronisers on both lines; ps2_clk then goes through the filter.
//   A falling edge of the filtered clock = one sample event, taking the synchronised ps2_dat.
//  Frame FSM: IDLE -> DATA on a sample with dat=0 (start bit).
//   A sample with dat=1 in IDLE is ignored.
//   DATA: 8 samples, LSB first -> PARITY: 1 sample; requires odd parity over data+parity bit.
//   -> STOP: 1 sample, must be 1 -> IDLE.
//   Good frame: code_valid pulses 1 cycle after the stop sample.
//   Bad parity or stop=0: frame_err pulses 1 cycle after the stop sample; no code_valid.
//   Timeout counter clears on every sample and counts while not IDLE.
//   Reaching TIMEOUT_CYCLES-1: -> IDLE and frame_err pulse; the partial frame is dropped.
//  Decode FSM (advances only on code_valid):
//   MAKE: F0 -> BRK; E0 -> EXT; letter code -> emit if code != held_code, then held_code=code;
//    any other code is ignored.
//   BRK: any code -> MAKE; if code == held_code, held_code=0.
//   EXT: F0 -> EXT_BRK; other -> MAKE (extended keys are never letters).
//   EXT_BRK: any -> MAKE.
//  Emit: char_input and char_pressed are registered 1 cycle after code_valid.
//   Total latency = 2 clk cycles after the clk cycle in which the stop sample occurs.
//  Typematic repeat (same make code while held) produces no strobe.
//  A different letter while one is still held emits and replaces held_code.
//  Set-2 map, letters A..Z:
//   1C 32 21 23 24 2B 34 33 43 3B 42 4B 3A 31 44 4D 15 2D 1B 2C 3C 2A 1D 22 35 1A.
//   Unmapped codes never strobe.
//  char_pressed and frame_err are never high in the same cycle as each other for the same frame.
//  They are never high for more than 1 cycle.
// STRUCTURE
//  Shared header enigma_defs.vh: SC_BREAK=8'hF0, SC_EXT=8'hE0, ASCII_A=8'h41, the 26-entry
//   scan->ASCII table (as a function or case macro), and the FSM state encodings.
//  Sub-module ps2_frame_rx: sync, filter, timeout and frame FSM.
//   Outputs code[7:0], code_valid, frame_err.
//  The top module holds the decode FSM, held_code and output registers.
// TESTING (bench drives PS/2 at 12.5 kHz, clk 50 MHz, TIMEOUT_CYCLES=50000)
//  1. Frame 1C -> char_pressed 1 cycle, char_input=8'h41, exactly 2 clk after stop sample.
//  2. Frames 1C,1C,1C (repeat) -> single strobe; then F0,1C,1C -> second strobe 8'h41.
//  3. Frame 2D with even parity -> frame_err 1 cycle, no char_pressed;
//     then a valid 1A -> 8'h5A.
//  4. Stop after 4 data bits for 60000 clk -> frame_err at timeout;
//     next full frame 24 -> 8'h45.
//  5. E0,75 then E0,F0,75 then 1C -> only one strobe (8'h41); E0-prefixed codes are ignored.
//  6. resetn low for 1 cycle mid-frame of 15, then frame 15 -> outputs 0 during reset;
//     one strobe 8'h51 afterwards.

Source files
------------

// File: rtl/ps2_key_capture_pkg.sv
// ps2_key_capture_pkg: shared scan codes, set-2 letter table and FSM state encodings.
package ps2_key_capture_pkg;
   localparam logic [7:0] SC_BREAK = 8'hF0;
   localparam logic [7:0] SC_EXT   = 8'hE0;
   localparam logic [7:0] ASCII_A  = 8'h41;
   localparam logic [7:0] SCAN_TBL [26] = '{
      8'h1C, 8'h32, 8'h21, 8'h23, 8'h24, 8'h2B, 8'h34, 8'h33, 8'h43, 8'h3B, 8'h42, 8'h4B, 8'h3A,
      8'h31, 8'h44, 8'h4D, 8'h15, 8'h2D, 8'h1B, 8'h2C, 8'h3C, 8'h2A, 8'h1D, 8'h22, 8'h35, 8'h1A};
   typedef enum logic [1:0] {F_IDLE, F_DATA, F_PARITY, F_STOP} frame_state_t;
   typedef enum logic [1:0] {D_MAKE, D_BRK, D_EXT, D_EXT_BRK} dec_state_t;
   // 8'h00 marks a code that is not a letter
   function automatic logic [7:0] scan_to_ascii(input logic [7:0] code);
      scan_to_ascii = 8'h00;
      for (int i = 0; i < 26; i++)
         if (code == SCAN_TBL[i]) scan_to_ascii = ASCII_A + 8'(i);
   endfunction
endpackage

// File: rtl/ps2_key_if.sv
// ps2_key_if: raw PS/2 lines in, decoded character strobe and frame error out.
interface ps2_key_if;
   logic       ps2_clk;
   logic       ps2_dat;
   logic [7:0] char_input;
   logic       char_pressed;
   logic       frame_err;
   modport master (output ps2_clk, ps2_dat, input char_input, char_pressed, frame_err);
   modport slave  (input ps2_clk, ps2_dat, output char_input, char_pressed, frame_err);
endinterface

// File: rtl/ps2_key_capture_frame_rx.sv
// ps2_frame_rx: synchronises and deglitches the PS/2 lines, deserialises one 11-bit frame,
// checks odd parity and stop bit, and aborts a stalled frame after a timeout.
module ps2_frame_rx
   import ps2_key_capture_pkg::*;
#(
   parameter int FILTER_LEN     = 8,
   parameter int TIMEOUT_CYCLES = 50000
) (
   input  logic       clk,
   input  logic       resetn,
   input  logic       ps2_clk,
   input  logic       ps2_dat,
   output logic [7:0] code,
   output logic       code_valid,
   output logic       frame_err
);
   localparam int FW = $clog2(FILTER_LEN + 1);
   localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
   logic [1:0]    clk_s, dat_s;
   logic          filt, accept, fall, to_hit, par_ok, par_n, cv_n, err_n;
   logic [FW-1:0] fcnt;
   logic [TW-1:0] to_cnt;
   logic [2:0]    bc, bc_n;
   logic [7:0]    sh_n;
   frame_state_t  state, state_n;
   // filtered level flips only after FILTER_LEN consecutive opposite samples
   assign accept = clk_s[1] != filt && fcnt == FW'(FILTER_LEN - 1);
   assign fall   = accept && filt;
   assign to_hit = state != F_IDLE && to_cnt == TW'(TIMEOUT_CYCLES - 1);
   always_comb begin
      state_n = state;
      sh_n    = code;
      bc_n    = bc;
      par_n   = par_ok;
      cv_n    = 1'b0;
      err_n   = 1'b0;
      if (to_hit) begin
         state_n = F_IDLE;
         err_n   = 1'b1;
      end else if (fall) begin
         case (state)
            F_IDLE:   if (!dat_s[1]) begin
               state_n = F_DATA;
               bc_n    = 3'd0;
            end
            F_DATA: begin
               sh_n    = {dat_s[1], code[7:1]};
               bc_n    = bc + 3'd1;
               state_n = bc == 3'd7 ? F_PARITY : F_DATA;
            end
            F_PARITY: begin
               par_n   = ^{code, dat_s[1]};
               state_n = F_STOP;
            end
            F_STOP: begin
               state_n = F_IDLE;
               cv_n    = dat_s[1] && par_ok;
               err_n   = !(dat_s[1] && par_ok);
            end
         endcase
      end
   end
   always_ff @(posedge clk) begin
      if (!resetn) begin
         clk_s      <= 2'b11;
         dat_s      <= 2'b11;
         filt       <= 1'b1;
         fcnt       <= '0;
         to_cnt     <= '0;
         state      <= F_IDLE;
         code       <= '0;
         bc         <= '0;
         par_ok     <= 1'b0;
         code_valid <= 1'b0;
         frame_err  <= 1'b0;
      end else begin
         clk_s      <= {clk_s[0], ps2_clk};
         dat_s      <= {dat_s[0], ps2_dat};
         filt       <= accept ? clk_s[1] : filt;
         fcnt       <= (clk_s[1] == filt || accept) ? '0 : fcnt + 1'b1;
         to_cnt     <= (fall || state == F_IDLE || to_hit) ? '0 : to_cnt + 1'b1;
         state      <= state_n;
         code       <= sh_n;
         bc         <= bc_n;
         par_ok     <= par_n;
         code_valid <= cv_n;
         frame_err  <= err_n;
      end
   end
endmodule

// File: rtl/ps2_key_capture.sv
// ps2_key_capture: decodes set-2 letter make codes to uppercase ASCII with a one-cycle strobe,
// suppressing break sequences, extended keys and typematic repeats.
module ps2_key_capture
   import ps2_key_capture_pkg::*;
#(
   parameter int FILTER_LEN     = 8,
   parameter int TIMEOUT_CYCLES = 50000
) (
   input  logic     clk,
   input  logic     resetn,
   ps2_key_if.slave bus
);
   logic [7:0] code, ascii, held, held_n, ch, ch_n;
   logic       code_valid, err, pr, pr_n;
   dec_state_t ds, ds_n;
   ps2_frame_rx #(.FILTER_LEN(FILTER_LEN), .TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_rx (
      .clk        (clk),
      .resetn     (resetn),
      .ps2_clk    (bus.ps2_clk),
      .ps2_dat    (bus.ps2_dat),
      .code       (code),
      .code_valid (code_valid),
      .frame_err  (err)
   );
   assign ascii = scan_to_ascii(code);
   always_comb begin
      ds_n   = ds;
      held_n = held;
      ch_n   = ch;
      pr_n   = 1'b0;
      if (code_valid) begin
         case (ds)
            D_MAKE:
               if (code == SC_BREAK) ds_n = D_BRK;
               else if (code == SC_EXT) ds_n = D_EXT;
               else if (ascii != 8'h00) begin
                  held_n = code;
                  pr_n   = code != held;
                  ch_n   = code != held ? ascii : ch;
               end
            D_BRK: begin
               ds_n   = D_MAKE;
               held_n = code == held ? 8'h00 : held;
            end
            D_EXT:     ds_n = code == SC_BREAK ? D_EXT_BRK : D_MAKE;
            D_EXT_BRK: ds_n = D_MAKE;
         endcase
      end
   end
   always_ff @(posedge clk) begin
      if (!resetn) begin
         ds   <= D_MAKE;
         held <= 8'h00;
         ch   <= 8'h00;
         pr   <= 1'b0;
      end else begin
         ds   <= ds_n;
         held <= held_n;
         ch   <= ch_n;
         pr   <= pr_n;
      end
   end
   assign bus.char_input   = ch;
   assign bus.char_pressed = pr;
   assign bus.frame_err    = err;
endmodule

// File: tb/tb_ps2_key_capture.sv
// tb_ps2_key_capture: drives PS/2 frames from a vector table and hand sequences,
// scoreboarding expected characters against observed strobes.
module tb_ps2_key_capture;
   localparam int FL  = 8;
   localparam int TO  = 500;
   localparam int H   = 20;
   localparam int LAT = FL + 3;
   typedef struct {
      logic [7:0] code;
      bit         bad_par;
      bit         bad_stop;
      logic [7:0] exp_char;
      int         exp_err;
   } vec_t;
   logic clk = 1'b0;
   logic resetn = 1'b0;
   int   cyc = 0, fall_cyc = 0, press_cyc = 0, n_err = 0, viol = 0;
   int   n_chk = 0, n_fail = 0;
   bit   prev_p = 1'b0, prev_e = 1'b0;
   logic [7:0] exp_q[$], got_q[$];
   vec_t tbl[$];
   ps2_key_if bus ();
   ps2_key_capture #(.FILTER_LEN(FL), .TIMEOUT_CYCLES(TO)) dut (.clk(clk), .resetn(resetn), .bus(bus));
   always #10 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;
   always @(posedge clk) begin
      #1;
      if (bus.char_pressed) begin
         got_q.push_back(bus.char_input);
         press_cyc = cyc;
      end
      if (bus.frame_err) n_err++;
      if ((bus.char_pressed && (prev_p || bus.frame_err)) || (bus.frame_err && prev_e)) viol++;
      prev_p = bus.char_pressed;
      prev_e = bus.frame_err;
   end
   task automatic check(input string name, input int act, input int exp);
      n_chk++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask
   task automatic send_frame(input logic [7:0] code, input bit bad_par, input bit bad_stop, input int n);
      logic [10:0] f;
      f = {~bad_stop, (~^code) ^ bad_par, code, 1'b0};
      for (int i = 0; i < n; i++) begin
         bus.ps2_dat = f[i];
         repeat (H) @(negedge clk);
         bus.ps2_clk = 1'b0;
         if (i == n - 1) fall_cyc = cyc;
         repeat (H) @(negedge clk);
         bus.ps2_clk = 1'b1;
      end
      bus.ps2_dat = 1'b1;
   endtask
   task automatic run_frame(input vec_t v, input string name);
      int e0;
      e0 = n_err;
      if (v.exp_char != 8'h00) exp_q.push_back(v.exp_char);
      send_frame(v.code, v.bad_par, v.bad_stop, 11);
      repeat (30) @(negedge clk);
      check({name, "_strobes"}, got_q.size(), exp_q.size());
      while (got_q.size() > 0 && exp_q.size() > 0) check({name, "_char"}, int'(got_q.pop_front()), int'(exp_q.pop_front()));
      check({name, "_err"}, n_err - e0, v.exp_err);
      exp_q.delete();
      got_q.delete();
   endtask
   initial begin
      int e0;
      bus.ps2_clk = 1'b1;
      bus.ps2_dat = 1'b1;
      tbl.push_back('{8'hF0, 1'b0, 1'b0, 8'h00, 0});
      tbl.push_back('{8'h1C, 1'b0, 1'b0, 8'h00, 0});
      tbl.push_back('{8'h1C, 1'b0, 1'b0, 8'h41, 0});
      tbl.push_back('{8'h1C, 1'b0, 1'b0, 8'h00, 0});
      tbl.push_back('{8'h1C, 1'b0, 1'b0, 8'h00, 0});
      tbl.push_back('{8'hF0, 1'b0, 1'b0, 8'h00, 0});
      tbl.push_back('{8'h1C, 1'b0, 1'b0, 8'h00, 0});
      tbl.push_back('{8'h1C, 1'b0, 1'b0, 8'h41, 0});
      tbl.push_back('{8'h2D, 1'b1, 1'b0, 8'h00, 1});
      tbl.push_back('{8'h1A, 1'b0, 1'b0, 8'h5A, 0});
      tbl.push_back('{8'h16, 1'b0, 1'b0, 8'h00, 0});
      tbl.push_back('{8'h3A, 1'b0, 1'b0, 8'h4D, 0});
      tbl.push_back('{8'h3A, 1'b0, 1'b0, 8'h00, 0});
      tbl.push_back('{8'h22, 1'b0, 1'b0, 8'h58, 0});
      tbl.push_back('{8'h42, 1'b0, 1'b1, 8'h00, 1});
      tbl.push_back('{8'hE0, 1'b0, 1'b0, 8'h00, 0});
      tbl.push_back('{8'h75, 1'b0, 1'b0, 8'h00, 0});
      tbl.push_back('{8'hE0, 1'b0, 1'b0, 8'h00, 0});
      tbl.push_back('{8'hF0, 1'b0, 1'b0, 8'h00, 0});
      tbl.push_back('{8'h75, 1'b0, 1'b0, 8'h00, 0});
      tbl.push_back('{8'h1C, 1'b0, 1'b0, 8'h41, 0});
      repeat (3) @(negedge clk);
      check("reset_char", int'(bus.char_input), 0);
      check("reset_pressed", int'(bus.char_pressed), 0);
      check("reset_err", int'(bus.frame_err), 0);
      resetn = 1'b1;
      repeat (5) @(negedge clk);
      run_frame('{8'h1C, 1'b0, 1'b0, 8'h41, 0}, "first_1C");
      check("first_latency", press_cyc - fall_cyc, LAT);
      foreach (tbl[i]) run_frame(tbl[i], $sformatf("vec%0d", i));
      // stall a frame after four data bits
      e0 = n_err;
      send_frame(8'h24, 1'b0, 1'b0, 5);
      repeat (300) @(negedge clk);
      check("timeout_early", n_err - e0, 0);
      repeat (300) @(negedge clk);
      check("timeout_err", n_err - e0, 1);
      check("timeout_no_strobe", got_q.size(), 0);
      run_frame('{8'h24, 1'b0, 1'b0, 8'h45, 0}, "after_timeout");
      send_frame(8'h15, 1'b0, 1'b0, 5);
      @(negedge clk);
      resetn = 1'b0;
      @(posedge clk);
      #1;
      check("midreset_char", int'(bus.char_input), 0);
      check("midreset_pressed", int'(bus.char_pressed), 0);
      @(negedge clk);
      resetn = 1'b1;
      repeat (5) @(negedge clk);
      run_frame('{8'h15, 1'b0, 1'b0, 8'h51, 0}, "after_reset");
      check("strobe_shape_violations", viol, 0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
